// File: rtl/mem_port_arb_if.sv
// Bus bundle between the LSQ, the data cache and the memory-port sequencer.
// The slave modport is the sequencer; the master modport is the LSQ/cache side.
interface mem_port_arb_if #(
    parameter int ADDR_W = 32,
    parameter int TAG_W  = 6
);
  logic              flush;
  logic              ld_req_valid;
  logic              ld_req_ready;
  logic [ADDR_W-1:0] ld_req_addr;
  logic [1:0]        ld_req_size;
  logic              ld_req_signed;
  logic [TAG_W-1:0]  ld_req_tag;
  logic              st_req_valid;
  logic              st_req_ready;
  logic [ADDR_W-1:0] st_req_addr;
  logic [31:0]       st_req_data;
  logic [1:0]        st_req_size;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_req_we;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [31:0]       mem_req_wdata;
  logic [3:0]        mem_req_wstrb;
  logic              mem_resp_valid;
  logic [31:0]       mem_resp_rdata;
  logic              ld_resp_valid;
  logic [TAG_W-1:0]  ld_resp_tag;
  logic [31:0]       ld_resp_data;
  logic              cache_stall;

  modport slave (
    input  flush,
    input  ld_req_valid, ld_req_addr, ld_req_size, ld_req_signed, ld_req_tag,
    output ld_req_ready,
    input  st_req_valid, st_req_addr, st_req_data, st_req_size,
    output st_req_ready,
    output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wstrb,
    input  mem_req_ready,
    input  mem_resp_valid, mem_resp_rdata,
    output ld_resp_valid, ld_resp_tag, ld_resp_data,
    output cache_stall
  );

  modport master (
    output flush,
    output ld_req_valid, ld_req_addr, ld_req_size, ld_req_signed, ld_req_tag,
    input  ld_req_ready,
    output st_req_valid, st_req_addr, st_req_data, st_req_size,
    input  st_req_ready,
    input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wstrb,
    output mem_req_ready,
    output mem_resp_valid, mem_resp_rdata,
    input  ld_resp_valid, ld_resp_tag, ld_resp_data,
    input  cache_stall
  );
endinterface

// File: rtl/mem_port_arb.sv
// Single-port data-memory sequencer: arbitrates loads (priority, with a store
// starvation guard) and committed stores onto one cache channel, one at a time.
module mem_port_arb #(
    parameter int ADDR_W     = 32,
    parameter int TAG_W      = 6,
    parameter int STARVE_MAX = 4
) (
    input logic         clk,
    input logic         rst,
    mem_port_arb_if.slave bus
);
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;

  state_t            state_reg;
  logic [CNT_W-1:0]  starve_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [1:0]        size_reg;
  logic              signed_reg;
  logic              we_reg;
  logic [TAG_W-1:0]  tag_reg;
  logic [31:0]       wdata_reg;
  logic [3:0]        wstrb_reg;
  logic              mem_req_valid_reg;
  logic              ld_resp_valid_reg;
  logic [TAG_W-1:0]  ld_resp_tag_reg;
  logic [31:0]       ld_resp_data_reg;

  logic        ld_ok;
  logic        grant_st;
  logic        grant_ld;
  logic        idle;
  logic [3:0]  st_strb_base;
  logic [31:0] rd_shifted;
  logic [31:0] ld_fmt;

  assign idle     = (state_reg == IDLE);
  assign ld_ok    = bus.ld_req_valid && !bus.flush;
  // A saturated counter hands the slot to a waiting store even if a load is ready.
  assign grant_st = bus.st_req_valid && (!ld_ok || (starve_reg == STARVE_LIM));
  assign grant_ld = ld_ok && !grant_st;

  assign bus.ld_req_ready  = idle && grant_ld;
  assign bus.st_req_ready  = idle && grant_st;
  assign bus.cache_stall   = !idle;
  assign bus.mem_req_valid = mem_req_valid_reg;
  assign bus.mem_req_we    = we_reg;
  assign bus.mem_req_addr  = {addr_reg[ADDR_W-1:2], 2'b00};
  assign bus.mem_req_wdata = wdata_reg;
  assign bus.mem_req_wstrb = wstrb_reg;
  assign bus.ld_resp_valid = ld_resp_valid_reg;
  assign bus.ld_resp_tag   = ld_resp_tag_reg;
  assign bus.ld_resp_data  = ld_resp_data_reg;

  always_comb begin
    st_strb_base = 4'b1111;
    case (bus.st_req_size)
      2'd0:    st_strb_base = 4'b0001;
      2'd1:    st_strb_base = 4'b0011;
      default: st_strb_base = 4'b1111;
    endcase
  end

  always_comb begin
    rd_shifted = bus.mem_resp_rdata >> {addr_reg[1:0], 3'b000};
    ld_fmt     = rd_shifted;
    case (size_reg)
      2'd0:    ld_fmt = {{24{signed_reg & rd_shifted[7]}}, rd_shifted[7:0]};
      2'd1:    ld_fmt = {{16{signed_reg & rd_shifted[15]}}, rd_shifted[15:0]};
      default: ld_fmt = rd_shifted;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg         <= IDLE;
      starve_reg        <= '0;
      addr_reg          <= '0;
      size_reg          <= '0;
      signed_reg        <= 1'b0;
      we_reg            <= 1'b0;
      tag_reg           <= '0;
      wdata_reg         <= '0;
      wstrb_reg         <= '0;
      mem_req_valid_reg <= 1'b0;
      ld_resp_valid_reg <= 1'b0;
      ld_resp_tag_reg   <= '0;
      ld_resp_data_reg  <= '0;
    end else begin
      ld_resp_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (grant_st) begin
            addr_reg          <= bus.st_req_addr;
            size_reg          <= bus.st_req_size;
            signed_reg        <= 1'b0;
            we_reg            <= 1'b1;
            wdata_reg         <= bus.st_req_data << {bus.st_req_addr[1:0], 3'b000};
            wstrb_reg         <= st_strb_base << bus.st_req_addr[1:0];
            starve_reg        <= '0;
            mem_req_valid_reg <= 1'b1;
            state_reg         <= REQ;
          end else if (grant_ld) begin
            addr_reg          <= bus.ld_req_addr;
            size_reg          <= bus.ld_req_size;
            signed_reg        <= bus.ld_req_signed;
            tag_reg           <= bus.ld_req_tag;
            we_reg            <= 1'b0;
            wdata_reg         <= '0;
            wstrb_reg         <= 4'b0000;
            if (bus.st_req_valid && (starve_reg != STARVE_LIM))
              starve_reg <= starve_reg + 1'b1;
            mem_req_valid_reg <= 1'b1;
            state_reg         <= REQ;
          end
        end
        REQ: begin
          if (bus.mem_req_ready) begin
            mem_req_valid_reg <= 1'b0;
            state_reg         <= (bus.flush && !we_reg) ? DRAIN : WAIT;
          end else if (bus.flush && !we_reg) begin
            // Request never reached the cache, so it can simply be withdrawn.
            mem_req_valid_reg <= 1'b0;
            state_reg         <= IDLE;
          end
        end
        WAIT: begin
          if (bus.mem_resp_valid) begin
            state_reg <= IDLE;
            if (!we_reg && !bus.flush) begin
              ld_resp_valid_reg <= 1'b1;
              ld_resp_tag_reg   <= tag_reg;
              ld_resp_data_reg  <= ld_fmt;
            end
          end else if (bus.flush && !we_reg) begin
            state_reg <= DRAIN;
          end
        end
        DRAIN: begin
          if (bus.mem_resp_valid) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arb.sv
// Directed vector bench for mem_port_arb: table of single transactions plus
// hand-written starvation, stall, flush and reset sequences.
module tb_mem_port_arb;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  mem_port_arb_if #(.ADDR_W(32), .TAG_W(6)) bus ();

  mem_port_arb #(.ADDR_W(32), .TAG_W(6), .STARVE_MAX(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic        is_st;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        sgn;
    logic [5:0]  tag;
    logic [31:0] data;
    logic [31:0] rdata;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_ld;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Presents one request in IDLE and leaves the bench at the first REQ-cycle negedge.
  task automatic issue(input logic st, input logic [31:0] addr, input logic [1:0] size,
                       input logic sgn, input logic [5:0] tag, input logic [31:0] data);
    @(negedge clk);
    if (st) begin
      bus.st_req_valid = 1'b1;
      bus.st_req_addr  = addr;
      bus.st_req_size  = size;
      bus.st_req_data  = data;
      #1 check("st_req_ready", {31'b0, bus.st_req_ready}, 32'd1);
    end else begin
      bus.ld_req_valid  = 1'b1;
      bus.ld_req_addr   = addr;
      bus.ld_req_size   = size;
      bus.ld_req_signed = sgn;
      bus.ld_req_tag    = tag;
      #1 check("ld_req_ready", {31'b0, bus.ld_req_ready}, 32'd1);
    end
    @(negedge clk);
    bus.ld_req_valid = 1'b0;
    bus.st_req_valid = 1'b0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    issue(v.is_st, v.addr, v.size, v.sgn, v.tag, v.data);
    check("req_stall", {31'b0, bus.cache_stall}, 32'd1);
    check("req_valid", {31'b0, bus.mem_req_valid}, 32'd1);
    check("req_we", {31'b0, bus.mem_req_we}, {31'b0, v.is_st});
    check("req_addr", bus.mem_req_addr, v.exp_addr);
    check("req_wstrb", {28'b0, bus.mem_req_wstrb}, {28'b0, v.exp_wstrb});
    if (v.is_st) check("req_wdata", bus.mem_req_wdata, v.exp_wdata);
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    bus.mem_req_ready = 1'b0;
    check("wait_valid", {31'b0, bus.mem_req_valid}, 32'd0);
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_rdata = v.rdata;
    @(negedge clk);
    bus.mem_resp_valid = 1'b0;
    check("resp_valid", {31'b0, bus.ld_resp_valid}, {31'b0, !v.is_st});
    if (!v.is_st) begin
      check("resp_data", bus.ld_resp_data, v.exp_ld);
      check("resp_tag", {26'b0, bus.ld_resp_tag}, {26'b0, v.tag});
    end
    check("resp_idle", {31'b0, bus.cache_stall}, 32'd0);
    $display("txn %0d %s addr=0x%08h size=%0d ld_data=0x%08h wdata=0x%08h errors=%0d",
             idx, v.is_st ? "ST" : "LD", v.addr, v.size, bus.ld_resp_data, v.exp_wdata, errors);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [5:0] grants;
    logic [5:0] exp_grants;
    int         ngr;

    bus.flush = 0; bus.ld_req_valid = 0; bus.ld_req_addr = 0; bus.ld_req_size = 0;
    bus.ld_req_signed = 0; bus.ld_req_tag = 0; bus.st_req_valid = 0; bus.st_req_addr = 0;
    bus.st_req_data = 0; bus.st_req_size = 0; bus.mem_req_ready = 0;
    bus.mem_resp_valid = 0; bus.mem_resp_rdata = 0;

    //             st    addr          sz    sgn   tag    data          rdata         exp_addr      exp_wdata     strb   exp_ld
    vecs[0] = '{1'b0, 32'h0000_1003, 2'd0, 1'b1, 6'd5,  32'h0,        32'h80AA_55CC, 32'h0000_1000, 32'h0,        4'h0, 32'hFFFF_FF80};
    vecs[1] = '{1'b1, 32'h0000_2002, 2'd1, 1'b0, 6'd0,  32'h0000_BEEF, 32'h0,        32'h0000_2000, 32'hBEEF_0000, 4'hC, 32'h0};
    vecs[2] = '{1'b0, 32'h0000_3002, 2'd1, 1'b0, 6'd9,  32'h0,        32'h8001_1234, 32'h0000_3000, 32'h0,        4'h0, 32'h0000_8001};
    vecs[3] = '{1'b0, 32'h0000_3002, 2'd1, 1'b1, 6'd10, 32'h0,        32'h8001_1234, 32'h0000_3000, 32'h0,        4'h0, 32'hFFFF_8001};
    vecs[4] = '{1'b0, 32'h0000_4000, 2'd2, 1'b1, 6'd33, 32'h0,        32'hDEAD_BEEF, 32'h0000_4000, 32'h0,        4'h0, 32'hDEAD_BEEF};
    vecs[5] = '{1'b1, 32'h0000_5001, 2'd0, 1'b0, 6'd0,  32'h0000_00A5, 32'h0,        32'h0000_5000, 32'h0000_A500, 4'h2, 32'h0};
    vecs[6] = '{1'b1, 32'h0000_6004, 2'd2, 1'b0, 6'd0,  32'h1234_5678, 32'h0,        32'h0000_6004, 32'h1234_5678, 4'hF, 32'h0};
    vecs[7] = '{1'b0, 32'h0000_7001, 2'd0, 1'b0, 6'd63, 32'h0,        32'h0000_9A00, 32'h0000_7000, 32'h0,        4'h0, 32'h0000_009A};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_ld_ready", {31'b0, bus.ld_req_ready}, 32'd0);
    check("rst_st_ready", {31'b0, bus.st_req_ready}, 32'd0);
    check("rst_req_valid", {31'b0, bus.mem_req_valid}, 32'd0);
    check("rst_req_addr", bus.mem_req_addr, 32'd0);
    check("rst_wstrb", {28'b0, bus.mem_req_wstrb}, 32'd0);
    check("rst_resp_valid", {31'b0, bus.ld_resp_valid}, 32'd0);
    check("rst_resp_data", bus.ld_resp_data, 32'd0);
    check("rst_stall", {31'b0, bus.cache_stall}, 32'd0);

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // Flush blocks a load grant in IDLE.
    @(negedge clk);
    bus.ld_req_valid = 1'b1; bus.flush = 1'b1;
    #1 check("flush_blocks_ld", {31'b0, bus.ld_req_ready}, 32'd0);
    @(negedge clk);
    bus.ld_req_valid = 1'b0; bus.flush = 1'b0;
    check("flush_blocks_idle", {31'b0, bus.cache_stall}, 32'd0);
    $display("txn flush-blocks-load errors=%0d", errors);

    // Starvation guard: loads and a store both valid continuously.
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    bus.ld_req_valid = 1'b1; bus.ld_req_addr = 32'h100; bus.ld_req_size = 2'd2; bus.ld_req_tag = 6'd1;
    bus.st_req_valid = 1'b1; bus.st_req_addr = 32'h200; bus.st_req_size = 2'd2; bus.st_req_data = 32'h55;
    bus.mem_req_ready = 1'b1; bus.mem_resp_valid = 1'b1; bus.mem_resp_rdata = 32'h0;
    grants = '0; ngr = 0;
    exp_grants = 6'b010000;
    for (int cyc = 0; cyc < 60 && ngr < 6; cyc++) begin
      #1;
      if (bus.ld_req_ready || bus.st_req_ready) begin
        check("both_ready", {31'b0, bus.ld_req_ready & bus.st_req_ready}, 32'd0);
        grants[ngr] = bus.st_req_ready;
        ngr++;
      end
      @(negedge clk);
    end
    bus.ld_req_valid = 1'b0; bus.st_req_valid = 1'b0;
    repeat (4) @(negedge clk);
    bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0;
    check("starve_ngrants", ngr, 32'd6);
    for (int i = 0; i < 6; i++) begin
      logic [5:0] eg;
      eg = exp_grants;
      check($sformatf("starve_grant%0d", i), {31'b0, grants[i]}, {31'b0, eg[i]});
    end
    $display("txn starvation grants(bit=store)=%b errors=%0d", grants, errors);

    // mem_req_ready held low for 5 cycles.
    issue(1'b0, 32'h0000_8002, 2'd1, 1'b0, 6'd17, 32'h0);
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", {31'b0, bus.mem_req_valid}, 32'd1);
      check("stall_addr", bus.mem_req_addr, 32'h0000_8000);
      check("stall_wstrb", {28'b0, bus.mem_req_wstrb}, 32'd0);
      check("stall_we", {31'b0, bus.mem_req_we}, 32'd0);
      check("stall_cache_stall", {31'b0, bus.cache_stall}, 32'd1);
      @(negedge clk);
    end
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b1; bus.mem_resp_rdata = 32'h7F01_0000;
    @(negedge clk);
    bus.mem_resp_valid = 1'b0;
    check("stall_resp_valid", {31'b0, bus.ld_resp_valid}, 32'd1);
    check("stall_resp_data", bus.ld_resp_data, 32'h0000_7F01);
    check("stall_resp_tag", {26'b0, bus.ld_resp_tag}, 32'd17);
    $display("txn ready-held-low errors=%0d", errors);

    // Flush in WAIT, response two cycles later, discarded via DRAIN.
    issue(1'b0, 32'h0000_9000, 2'd2, 1'b0, 6'd3, 32'h0);
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    bus.mem_req_ready = 1'b0; bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("drain_stall", {31'b0, bus.cache_stall}, 32'd1);
    check("drain_no_resp", {31'b0, bus.ld_resp_valid}, 32'd0);
    @(negedge clk);
    bus.mem_resp_valid = 1'b1; bus.mem_resp_rdata = 32'h1111_1111;
    @(negedge clk);
    bus.mem_resp_valid = 1'b0;
    check("drain_discard", {31'b0, bus.ld_resp_valid}, 32'd0);
    check("drain_idle", {31'b0, bus.cache_stall}, 32'd0);
    $display("txn flush-in-wait errors=%0d", errors);

    // Flush while a store sits in REQ: store proceeds.
    issue(1'b1, 32'h0000_A000, 2'd2, 1'b0, 6'd0, 32'hCAFE_F00D);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("st_flush_valid", {31'b0, bus.mem_req_valid}, 32'd1);
    check("st_flush_we", {31'b0, bus.mem_req_we}, 32'd1);
    check("st_flush_wdata", bus.mem_req_wdata, 32'hCAFE_F00D);
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b1;
    @(negedge clk);
    bus.mem_resp_valid = 1'b0;
    check("st_flush_no_resp", {31'b0, bus.ld_resp_valid}, 32'd0);
    check("st_flush_idle", {31'b0, bus.cache_stall}, 32'd0);
    $display("txn flush-store-in-req errors=%0d", errors);

    // Flush on a load in REQ without ready: request withdrawn.
    issue(1'b0, 32'h0000_B000, 2'd2, 1'b0, 6'd4, 32'h0);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("withdraw_valid", {31'b0, bus.mem_req_valid}, 32'd0);
    check("withdraw_idle", {31'b0, bus.cache_stall}, 32'd0);
    $display("txn flush-load-in-req errors=%0d", errors);

    // Flush together with mem_req_ready: DRAIN.
    issue(1'b0, 32'h0000_C000, 2'd2, 1'b0, 6'd6, 32'h0);
    bus.flush = 1'b1; bus.mem_req_ready = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0; bus.mem_req_ready = 1'b0;
    check("flush_ready_stall", {31'b0, bus.cache_stall}, 32'd1);
    check("flush_ready_valid", {31'b0, bus.mem_req_valid}, 32'd0);
    bus.mem_resp_valid = 1'b1;
    @(negedge clk);
    bus.mem_resp_valid = 1'b0;
    check("flush_ready_no_resp", {31'b0, bus.ld_resp_valid}, 32'd0);
    check("flush_ready_idle", {31'b0, bus.cache_stall}, 32'd0);
    $display("txn flush-with-ready errors=%0d", errors);

    // Reset mid-transaction.
    issue(1'b0, 32'h0000_D000, 2'd2, 1'b0, 6'd7, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_idle", {31'b0, bus.cache_stall}, 32'd0);
    check("midrst_valid", {31'b0, bus.mem_req_valid}, 32'd0);
    $display("txn reset-mid-transaction errors=%0d", errors);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
